// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, step count and result constants.
package alu_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = $clog2(WIDTH) + 1;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/divstep32.sv
// One restoring shift-subtract iteration of the divider, purely combinational.
module divstep32
  import alu_pkg::*;
(
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] quo_sh;
  logic             ge;

  assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign quo_sh  = {quo[WIDTH-2:0], 1'b0};
  // A set top bit means the shifted value already exceeds any WIDTH-bit divisor.
  assign ge      = rem[WIDTH] | (shifted >= {1'b0, divisor});

  always_comb begin
    rem_next = shifted;
    quo_next = quo_sh;
    if (ge) begin
      rem_next = shifted - {1'b0, divisor};
      quo_next = quo_sh | WIDTH'(1);
    end
  end

endmodule

// File: rtl/div32.sv
// Iterative 32-bit restoring divider for DIV/DIVU: one step per clock, sign fixup
// folded into the final step so results and the done pulse appear on entry to FIX.
module div32
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [WIDTH:0]   rem, rem_d;
  logic [WIDTH-1:0] quo, quo_d;
  logic [WIDTH-1:0] dvs, dvs_d;
  logic             neg_q, neg_q_d;
  logic             neg_r, neg_r_d;
  logic             busy_d, done_d, dbz_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] step_rem_lo;

  assign abs_a       = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b       = (signed_op && b[WIDTH-1]) ? -b : b;
  assign step_rem_lo = step_rem[WIDTH-1:0];

  divstep32 u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    count_d     = count;
    rem_d       = rem;
    quo_d       = quo;
    dvs_d       = dvs;
    neg_q_d     = neg_q;
    neg_r_d     = neg_r;
    done_d      = 1'b0;
    quotient_d  = quotient;
    remainder_d = remainder;
    dbz_d       = div_by_zero;

    unique case (state)
      IDLE: begin
        if (start) begin
          neg_q_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_d = signed_op & a[WIDTH-1];
          quo_d   = abs_a;
          rem_d   = '0;
          dvs_d   = abs_b;
          count_d = '0;
          if (b == '0) begin
            // Divide by zero bypasses the loop and its sign fixup entirely.
            state_d     = FIX;
            done_d      = 1'b1;
            quotient_d  = DIV0_QUOTIENT;
            remainder_d = a;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count + CNT_W'(1);
        if (count == CNT_W'(DIV_STEPS - 1)) begin
          state_d     = FIX;
          done_d      = 1'b1;
          quotient_d  = neg_q ? -step_quo : step_quo;
          remainder_d = neg_r ? -step_rem_lo : step_rem_lo;
          dbz_d       = 1'b0;
        end
      end
      FIX: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      rem         <= rem_d;
      quo         <= quo_d;
      dvs         <= dvs_d;
      neg_q       <= neg_q_d;
      neg_r       <= neg_r_d;
      busy        <= busy_d;
      done        <= done_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule
